// File: rtl/mem_stage.sv
// mem_stage: LC-3b MEM pipeline stage; runs direct/indirect data-memory accesses
// over a request/response handshake and stalls upstream while one is outstanding.
package mem_stage_pkg;
  typedef struct packed {
    logic       load_regfile;
    logic [2:0] dest;
    logic       mem_read;
    logic       mem_write;
    logic       mem_byte;
    logic       mem_indirect;
  } ctrl_t;
  typedef struct packed {
    logic [15:0] intr;
    logic [15:0] pc_out;
    logic [15:0] alu_out;
    logic [15:0] srcb_out;
    ctrl_t       control_signals;
  } EX_MEM;
  typedef struct packed {
    logic [15:0] intr;
    logic [15:0] pc_out;
    logic [15:0] alu_out;
    logic [15:0] mem_rdata;
    ctrl_t       control_signals;
  } MEM_WB;
endpackage

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  EX_MEM             ex_mem_out,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [ADDR_W-1:0] dmem_address,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [1:0]        dmem_byte_enable,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_resp,
  output logic              pipe_load,
  output MEM_WB             mem_wb_out
);
  typedef enum logic [1:0] {IDLE, PTR, DATA, DONE} state_t;
  state_t      r_state;
  logic [15:0] r_ptr;
  logic [15:0] r_rdata;
  logic        r_write;
  ctrl_t       w_ctrl;
  logic        w_mem_op;
  logic [15:0] w_addr;
  logic [15:0] w_byte_rd;
  logic [15:0] w_rdata;
  MEM_WB       w_wb;

  assign w_ctrl    = ex_mem_out.control_signals;
  assign w_mem_op  = w_ctrl.mem_read | w_ctrl.mem_write;
  assign w_addr    = w_ctrl.mem_indirect ? r_ptr : ex_mem_out.alu_out;
  assign w_byte_rd = w_addr[0] ? {8'h00, r_rdata[15:8]} : {8'h00, r_rdata[7:0]};
  assign w_rdata   = r_write ? 16'h0000 : w_ctrl.mem_byte ? w_byte_rd : r_rdata;

  // Direction is latched on leaving IDLE so the request strobes depend on state only.
  assign dmem_read        = (r_state == PTR) | ((r_state == DATA) & ~r_write);
  assign dmem_write       = (r_state == DATA) & r_write;
  assign dmem_address     = (r_state == PTR) ? {ex_mem_out.alu_out[15:1], 1'b0} :
                            w_ctrl.mem_byte ? w_addr : {w_addr[15:1], 1'b0};
  assign dmem_wdata       = w_ctrl.mem_byte ? {2{ex_mem_out.srcb_out[7:0]}} : ex_mem_out.srcb_out;
  assign dmem_byte_enable = ~w_ctrl.mem_byte ? 2'b11 : w_addr[0] ? 2'b10 : 2'b01;
  assign pipe_load        = ((r_state == IDLE) & ~w_mem_op) | (r_state == DONE);

  always_comb begin
    w_wb = '0;
    if (pipe_load) begin
      w_wb.intr            = ex_mem_out.intr;
      w_wb.pc_out          = ex_mem_out.pc_out;
      w_wb.alu_out         = ex_mem_out.alu_out;
      w_wb.mem_rdata       = (r_state == DONE) ? w_rdata : 16'h0000;
      w_wb.control_signals = w_ctrl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_rdata    <= '0;
      r_write    <= 1'b0;
      mem_wb_out <= '0;
    end else begin
      mem_wb_out <= w_wb;
      case (r_state)
        IDLE: if (w_mem_op) begin
          r_state <= w_ctrl.mem_indirect ? PTR : DATA;
          r_write <= w_ctrl.mem_write;
        end
        PTR: if (dmem_resp) begin
          r_ptr   <= dmem_rdata;
          r_state <= DATA;
        end
        DATA: if (dmem_resp) begin
          r_rdata <= dmem_rdata;
          r_state <= DONE;
        end
        DONE: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- LC-3b pipeline MEM stage, directly downstream of execute; consumes the EX_MEM pipeline register and produces the MEM_WB pipeline register.
- Runs data-memory accesses (LDR/STR, LDB/STB, LDI/STI) through a request/response handshake.
- Drives the pipeline-wide load enable so upstream registers freeze while an access is outstanding.

Parameters:
- ADDR_W, 16, data-memory address width (lc3b_word).
- DATA_W, 16, data-memory word width.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ex_mem_out  in  $bits(EX_MEM)  EX_MEM register contents: intr, pc_out, alu_out, srcb_out, control_signals
- dmem_read  out  1  read request, held until dmem_resp
- dmem_write  out  1  write request, held until dmem_resp
- dmem_address  out  ADDR_W  access address
- dmem_wdata  out  DATA_W  store data
- dmem_byte_enable  out  2  byte lanes for a write; [0]=low byte
- dmem_rdata  in  DATA_W  read data, valid with dmem_resp
- dmem_resp  in  1  single-cycle access-complete strobe
- pipe_load  out  1  1 = all upstream pipeline registers (incl. EX_MEM) load this cycle
- mem_wb_out  out  $bits(MEM_WB)  MEM_WB register: intr, pc_out, alu_out, mem_rdata, control_signals

Behaviour:
- Reset is asynchronous: state=IDLE, ptr_reg=0, rdata_reg=0, mem_wb_out=all-zero, which is a bubble (control_signals zero, no regfile write). dmem_read and dmem_write deassert immediately. The memory must tolerate a request dropped mid-access.
- Control fields used: mem_read, mem_write, mem_byte, mem_indirect. A memory op is mem_read|mem_write. If both are set, write wins. mem_indirect with neither set is a non-memory op.
- FSM states: IDLE, PTR, DATA, DONE. dmem_read and dmem_write are functions of state only (Moore).
- IDLE, non-memory op: pipe_load=1. MEM_WB loads {intr, pc_out, alu_out, mem_rdata=0, control_signals}. Stay in IDLE.
- IDLE, memory op: pipe_load=0; MEM_WB loads a bubble. Next state is PTR if mem_indirect, else DATA.
- PTR: dmem_read=1, dmem_address={alu_out[15:1],1'b0}.
  - On dmem_resp: ptr_reg<=dmem_rdata, go to DATA.
- DATA: final address A = mem_indirect ? ptr_reg : alu_out.
  - Word access: dmem_address={A[15:1],0}; write lanes 2'b11; wdata=srcb_out.
  - Byte access (mem_byte, ignored on the PTR read): dmem_address=A; wdata={srcb_out[7:0],srcb_out[7:0]}; lanes = A[0] ? 2'b10 : 2'b01.
  - dmem_read or dmem_write is asserted per op. On dmem_resp: rdata_reg<=dmem_rdata, go to DONE.
- DONE: pipe_load=1. MEM_WB loads the EX_MEM fields with mem_rdata:
  - word: rdata_reg.
  - byte: zero-extended rdata_reg[15:8] if A[0], else rdata_reg[7:0].
  - store: 0.
  - Next state IDLE.
- While pipe_load=0 the MEM_WB register loads an all-zero bubble every cycle, so WB never sees a duplicate.
- dmem_resp in IDLE or DONE is ignored.
- Latency, EX_MEM presented to MEM_WB update:
  - non-memory op: 1 cycle.
  - direct access: 2 + N cycles, where N ≥ 1 is the number of DATA cycles up to and including resp.
  - indirect access: 2 + P + N cycles, where P is the number of PTR cycles.
  - Back-to-back memory ops insert no extra idle cycles beyond IDLE.
- No timeout: a missing resp hangs the stage in PTR or DATA (intentional).

Test Plan:
- Reset: assert rst_n=0 while in DATA with dmem_read=1 → dmem_read drops before the next clk edge; mem_wb_out=0; after release, state is IDLE and the first non-memory op produces pipe_load=1.
- ADD passthrough: alu_out=16'h0005, no memory op → pipe_load=1 in the same cycle; next edge mem_wb_out.alu_out=16'h0005, mem_rdata=0.
- LDR: alu_out=16'h1235, memory responds with 16'hBEEF after 3 cycles → dmem_address=16'h1234; pipe_load low for 4 cycles, then high in DONE; mem_rdata=16'hBEEF.
- STB: alu_out=16'h2001, srcb_out=16'h00A5 → dmem_write=1, dmem_address=16'h2001, wdata=16'hA5A5, byte_enable=2'b10. LDB from 16'h2001 with rdata 16'h7F00 → mem_rdata=16'h007F.
- LDI: alu_out=16'h3000. Memory returns 16'h4000 on the pointer read, then 16'h1111 → the two reads go to 16'h3000 and then 16'h4000; mem_rdata=16'h1111. STI: the second access is a write to the pointer address with srcb_out.
- Spurious resp: dmem_resp=1 in IDLE with a non-memory op → no state change; rdata_reg unchanged. An op with both mem_read and mem_write set issues a write only.
